// File: rtl/register_bank.sv
// General-purpose register file: one synchronous write port, two combinational read ports.
// Register 0 has no storage and always reads zero.
module register_bank #(
    parameter int ADDRESS_SIZE  = 5,
    parameter int REGISTER_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [ADDRESS_SIZE-1:0]  addr_in,
    input  logic [REGISTER_SIZE-1:0] data_in,
    input  logic [ADDRESS_SIZE-1:0]  addr_out1,
    input  logic [ADDRESS_SIZE-1:0]  addr_out2,
    output logic [REGISTER_SIZE-1:0] data_out1,
    output logic [REGISTER_SIZE-1:0] data_out2
);

    localparam int DEPTH = 2 ** ADDRESS_SIZE;

    generate
        if (ADDRESS_SIZE < 1) begin : g_bad_address_size
            $error("register_bank: ADDRESS_SIZE must be >= 1");
        end
        if (REGISTER_SIZE < 1) begin : g_bad_register_size
            $error("register_bank: REGISTER_SIZE must be >= 1");
        end
    endgenerate

    logic [REGISTER_SIZE-1:0] r_regs [1:DEPTH-1];
    logic                     w_wr_en;

    assign w_wr_en = write && (addr_in != '0);

    // Reset takes priority over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[addr_in] <= data_in;
        end
    end

    // No write-to-read bypass: a same-cycle write shows up only after the edge.
    assign data_out1 = (addr_out1 == '0) ? '0 : r_regs[addr_out1];
    assign data_out2 = (addr_out2 == '0) ? '0 : r_regs[addr_out2];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed plan steps plus randomized
// traffic checked against an array-based reference model.
module tb_register_bank;

    localparam int AS    = 5;
    localparam int RS    = 32;
    localparam int NREGS = 2 ** AS;

    logic          clk;
    logic          reset;
    logic          write;
    logic [AS-1:0] addr_in;
    logic [RS-1:0] data_in;
    logic [AS-1:0] addr_out1;
    logic [AS-1:0] addr_out2;
    logic [RS-1:0] data_out1;
    logic [RS-1:0] data_out2;

    int tests = 0;
    int fails = 0;

    logic [RS-1:0] model [NREGS];

    register_bank #(
        .ADDRESS_SIZE  (AS),
        .REGISTER_SIZE (RS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .addr_out1 (addr_out1),
        .addr_out2 (addr_out2),
        .data_out1 (data_out1),
        .data_out2 (data_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RS-1:0] expect_rd(input int a);
        return (a == 0) ? '0 : model[a];
    endfunction

    task automatic check(input string tag, input logic [RS-1:0] obs, input logic [RS-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input int a1, input int a2, input string tag);
        addr_out1 = AS'(a1);
        addr_out2 = AS'(a2);
        #1;
        check($sformatf("%s rd1[%0d]", tag, a1), data_out1, expect_rd(a1));
        check($sformatf("%s rd2[%0d]", tag, a2), data_out2, expect_rd(a2));
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            read_check(a, NREGS - 1 - a, tag);
        end
    endtask

    // One clock edge with the given controls; inputs return to idle afterwards.
    task automatic do_cycle(input logic rst, input logic we, input int a, input logic [RS-1:0] d);
        @(negedge clk);
        reset   = rst;
        write   = we;
        addr_in = AS'(a);
        data_in = d;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) model[i] = '0;
        end else if (we && a != 0) begin
            model[a] = d;
        end
        #1;
        reset = 1'b1;
        write = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        write     = 1'b0;
        addr_in   = '0;
        data_in   = '0;
        addr_out1 = '0;
        addr_out2 = '0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        // Register 0 reads zero even before any reset.
        #1;
        check("pre-reset rd1[0]", data_out1, '0);
        check("pre-reset rd2[0]", data_out2, '0);

        // 1. Reset held two edges while a write is presented.
        do_cycle(1'b0, 1'b1, 3, 32'hAA);
        do_cycle(1'b0, 1'b1, 3, 32'hAA);
        sweep("reset");
        read_check(3, 3, "reset-priority");
        check("reset-priority reg3", data_out1, '0);

        // 2. Sequential fill.
        for (int k = 1; k < NREGS; k++) do_cycle(1'b1, 1'b1, k, RS'(k - 1));
        for (int k = 1; k < NREGS; k++) begin
            read_check(k, NREGS - k, "fill");
            check($sformatf("fill lit rd1[%0d]", k), data_out1, RS'(k - 1));
            check($sformatf("fill lit rd2[%0d]", NREGS - k), data_out2, RS'(NREGS - 1 - k));
        end

        // 3. Read during write: old value before the edge, new value after.
        do_cycle(1'b1, 1'b1, 5, 32'h11);
        @(negedge clk);
        write     = 1'b1;
        addr_in   = AS'(5);
        data_in   = 32'h22;
        addr_out1 = AS'(5);
        addr_out2 = AS'(5);
        #1;
        check("rdw before edge rd1", data_out1, 32'h11);
        check("rdw before edge rd2", data_out2, 32'h11);
        @(posedge clk);
        model[5] = 32'h22;
        #1;
        write = 1'b0;
        check("rdw after edge rd1", data_out1, 32'h22);
        check("rdw after edge rd2", data_out2, 32'h22);

        // 4. Writes to register 0 are ignored.
        do_cycle(1'b1, 1'b1, 0, 32'hFF);
        sweep("reg0-write");

        // 5. Write disabled.
        do_cycle(1'b1, 1'b1, 7, 32'h33);
        for (int n = 0; n < 3; n++) do_cycle(1'b1, 1'b0, 7, 32'h44);
        read_check(7, 7, "write-disable");
        check("write-disable lit", data_out1, 32'h33);

        // 6. Reset pulse mid-operation after a full random fill.
        for (int k = 1; k < NREGS; k++) do_cycle(1'b1, 1'b1, k, ($urandom() | 32'h1));
        sweep("prefill");
        do_cycle(1'b0, 1'b0, 0, '0);
        sweep("mid-reset");
        do_cycle(1'b1, 1'b1, 9, 32'h5A);
        read_check(9, 0, "post-reset write");
        check("post-reset lit reg9", data_out1, 32'h5A);

        // Randomized traffic, including the max address and occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic rst_n;
            rst_n = ($urandom_range(0, 29) != 0);
            do_cycle(rst_n, $urandom_range(0, 3) != 0, $urandom_range(0, NREGS - 1), $urandom());
            read_check($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1), "random");
            read_check(NREGS - 1, $urandom_range(0, NREGS - 1), "random-max");
        end
        sweep("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- General-purpose register file for the processor datapath.
- One synchronous write port and two independent asynchronous read ports.
- Feeds the two source operands to the execute stage and accepts write-back data.
- Register 0 is hardwired to zero.

Parameters:
ADDRESS_SIZE, 5, width of each register address; the bank holds 2**ADDRESS_SIZE registers.
REGISTER_SIZE, 32, width in bits of each register and of all data ports.

Ports:
clk  input  1  system clock; all state changes occur on the rising edge.
reset  input  1  synchronous, active-low reset; when 0 at a rising edge, all registers clear.
write  input  1  write enable, active-high.
addr_in  input  ADDRESS_SIZE  write address.
data_in  input  REGISTER_SIZE  write data.
addr_out1  input  ADDRESS_SIZE  read port 1 address.
addr_out2  input  ADDRESS_SIZE  read port 2 address.
data_out1  output  REGISTER_SIZE  read port 1 data.
data_out2  output  REGISTER_SIZE  read port 2 data.

Behaviour:
Clock and reset:
- Single clock domain; reset is synchronous and active-low.
- Rising edge with reset==0: every register becomes 0. Any write in that cycle is discarded, because reset has priority over write.
- Reset asserted mid-operation takes effect at the next rising edge only; contents are unchanged between edges.

Write port:
- Rising edge with reset==1 and write==1: reg[addr_in] <= data_in.
- write==0: no register changes.
- Exception: when addr_in==0 the write is silently ignored; reg[0] stays 0.
- Write latency is one edge; the new value is visible on the read ports immediately after that edge.

Read ports:
- Purely combinational: data_outN = (addr_outN==0) ? 0 : reg[addr_outN]. Outputs follow address changes with zero clock latency.
- No internal write-to-read bypass. If addr_outN==addr_in with write==1, data_outN shows the old value until the rising edge, then the new value.
- Both read ports may address the same register; both then return the same value.
- Read addresses may equal the write address with no restriction.

Output reset values:
- After reset, data_out1 and data_out2 read 0 for every address.
- Before the first reset, contents are undefined (X in simulation), except reg[0], which always reads 0.

Width and addressing rules:
- Data is stored and returned unmodified; no sign extension or truncation.
- All 2**ADDRESS_SIZE addresses are valid; there is no out-of-range case.
- Maximum address (31 at the default size) behaves like any other nonzero register.

Implementation notes:
- Storage is an array of 2**ADDRESS_SIZE-1 flops (entries 1..N-1). Entry 0 needs no storage.
- Expected size: about 120-200 lines of RTL, including parameter checks: ADDRESS_SIZE>=1, REGISTER_SIZE>=1.

Test Plan:
1. Reset: hold reset=0 for 2 edges with write=1, addr_in=3, data_in=0xAA, then release. Sweep addr_out1/addr_out2 over all 32 addresses -> every read is 0, and reg[3] is 0 because reset has priority.
2. Sequential fill (ADDRESS_SIZE=5, REGISTER_SIZE=8): write=1, addr_in=k, data_in=k-1 for k=1..31, one per clock. Then read addr_out1=k, addr_out2=32-k -> data_out1=k-1 and data_out2=31-k.
3. Read-during-write: reg[5]=0x11. Set addr_in=5, data_in=0x22, write=1, addr_out1=5 -> data_out1=0x11 before the edge and 0x22 immediately after.
4. Register 0: write=1, addr_in=0, data_in=0xFF, clock -> data_out1 and data_out2 read 0 at addr 0; no other register changes.
5. Write disable: reg[7]=0x33. Set write=0, addr_in=7, data_in=0x44, clock 3 times -> reg[7] still reads 0x33 on both ports.
6. Reset mid-operation: fill registers 1..31 with nonzero values, pulse reset=0 for one edge, then release -> all reads return 0; the first subsequent write (addr 9, 0x5A) reads back 0x5A.
